exp_mul_axi_cmd_master: RTL and testbench
=========================================

Name: exp_mul_axi_cmd_master

Overview:
- AXI4-Lite master sequencer directly upstream of the exponent/multiplier AXI4-Lite slave.
- Accepts one job (A, B, select) on a valid/ready command port.
- Runs the full register sequence on the bus: write A, write B, write SELECT, write START, poll DONE, read P.
- Returns P on a valid/ready response port, so fabric logic can use the accelerator without a CPU.

Parameters:
- BASE_ADDR, 32'h7c800000, slave base address. Register offsets are fixed: A +0x00, B +0x04, SELECT +0x08, START +0x0C, P +0x10, DONE +0x14.
- POLL_LIMIT, 1024, maximum DONE reads before timeout (used only with POLL_TIMEOUT_EN).
- CNT_W, 11, width of the poll counter; must hold POLL_LIMIT.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted when cmd_valid & cmd_ready
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_select  in  1  0 = multiply, 1 = exponent
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_p  out  30  result P (RDATA[29:0])
- rsp_err  out  1  timeout, or non-OKAY BRESP/RRESP seen during the job
- M_AXI_AWADDR  out  32;  M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  32;  M_AXI_WSTRB  out  4;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  32;  M_AXI_ARVALID  out  1;  M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; every output 0 except cmd_ready = 1. rsp_p = 0, rsp_err = 0, poll counter = 0.
- IDLE: cmd_ready = 1. On cmd_valid, latch a/b/select, clear the error flag, drop cmd_ready, go to WR_A.
- Write phase, used by WR_A, WR_B, WR_SEL, WR_START:
  - Drive AWADDR and WDATA. WDATA is zero-extended {28'b0, a} / {28'b0, b} / {31'b0, sel} / 32'h1. WSTRB = 4'hF.
  - Assert AWVALID and WVALID in the same cycle and hold both until AWREADY and WREADY have each been seen. Each handshake is tracked separately; the channel that is done deasserts its VALID.
  - The slave raises both READYs in the same cycle; the master must still tolerate them arriving in different cycles.
  - BREADY is asserted from the first AW/W cycle. BVALID & BREADY completes the write.
  - BRESP != 2'b00 sets the error flag; the sequence continues.
  - Order of completion: WR_A -> WR_B -> WR_SEL -> WR_START -> RD_DONE.
- RD_DONE:
  - Drive ARADDR = BASE+0x14 and assert ARVALID until ARREADY; RREADY = 1.
  - On RVALID: if RDATA[0] = 1, go to RD_P; otherwise increment the poll counter and reissue the read on the next cycle.
- RD_P:
  - Read BASE+0x10 the same way. On RVALID, rsp_p <= RDATA[29:0]. RRESP != 0 sets the error flag.
  - Go to RESP.
- RESP: rsp_valid = 1 and rsp_err = error flag, held stable until rsp_ready. Then clear rsp_valid and return to IDLE (cmd_ready = 1 the next cycle).
- Latency: minimum of 3 cycles per write and 3 per read under the slave's timing. No new command is accepted before the response is consumed; a single job is outstanding at a time.
- AR and AW are never active together; reads start only after the START write's B handshake.
- Reset mid-job: all VALIDs drop immediately, the job is discarded, and no response is issued.
- rsp_ready held high in IDLE has no effect. cmd_valid during a busy job is ignored (cmd_ready = 0).

Optional Feature:
- Macro: POLL_TIMEOUT_EN.
- Defined: if the poll counter reaches POLL_LIMIT with DONE still 0, skip RD_P and go to RESP with rsp_err = 1 and rsp_p = 0. The counter clears in IDLE.
- Undefined: polling is unbounded; rsp_err reflects only BRESP/RRESP; the counter logic is removed.

Test Plan:
- Slave model, DONE after 3 polls, P = 15; cmd a = 3, b = 5, sel = 0 -> writes in order: 0x7c800000 = 3, 0x7c800004 = 5, 0x7c800008 = 0, 0x7c80000C = 1; exactly 4 DONE reads; rsp_p = 15, rsp_err = 0.
- cmd a = 2, b = 4, sel = 1 with the model returning P = 16 -> SELECT write data = 1, rsp_p = 16; rsp_valid held 5 cycles with rsp_ready = 0, then consumed on the 6th cycle -> cmd_ready = 1 the following cycle.
- Model delays WREADY 2 cycles after AWREADY -> AWVALID drops after its handshake, WVALID held until WREADY; exactly one write per register.
- Model returns BRESP = 2'b10 on the B write -> sequence completes, rsp_err = 1, rsp_p is still the read value.
- POLL_TIMEOUT_EN, POLL_LIMIT = 8, DONE never set -> 8 DONE reads, no P read, rsp_err = 1, rsp_p = 0.
- Assert M_AXI_ARESETN low during the RD_DONE poll -> ARVALID, rsp_valid = 0 immediately, cmd_ready = 1; the next job runs normally.

Source files
------------

// File: rtl/exp_mul_axi_cmd_master.sv
// AXI4-Lite sequencer: one (a,b,select) job -> write A,B,SELECT,START, poll DONE, read P, return P.
// Latency: >= 3 cycles per bus write/read; one job outstanding, ~6 bus transactions plus polls.
// Backpressure: cmd_ready only in IDLE; rsp held until rsp_ready. Optional macro POLL_TIMEOUT_EN bounds polling.
module exp_mul_axi_cmd_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h7c800000,
    parameter int          POLL_LIMIT = 1024,
    parameter int          CNT_W      = 11
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_a,
    input  logic [3:0]  cmd_b,
    input  logic        cmd_select,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [29:0] rsp_p,
    output logic        rsp_err,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_WR_B, S_WR_SEL, S_WR_START, S_RD_DONE, S_RD_P, S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  a_q, a_d, b_q, b_d;
    logic        sel_q, sel_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d, ar_done_q, ar_done_d;
    logic        err_q, err_d;
    logic [29:0] p_q, p_d;
    logic        is_wr, is_rd;
    logic [31:0] wr_addr, wr_data, rd_addr;
    state_t      wr_next;
`ifdef POLL_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_ok;
    assign unused_ok = ^M_AXI_RDATA[31:30];
`else
    logic             unused_ok;
    assign unused_ok = ^{M_AXI_RDATA[31:30], POLL_LIMIT[0], CNT_W[0]};
`endif

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
            err_q     <= 1'b0;
            p_q       <= '0;
`ifdef POLL_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_done_q <= ar_done_d;
            err_q     <= err_d;
            p_q       <= p_d;
`ifdef POLL_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Address, data and successor for each register-write state.
    always_comb begin
        wr_addr = BASE_ADDR;
        wr_data = 32'h0;
        wr_next = S_WR_B;
        rd_addr = BASE_ADDR + 32'h14;
        case (state_q)
            S_WR_A:     begin wr_addr = BASE_ADDR;           wr_data = {28'b0, a_q};  wr_next = S_WR_B;     end
            S_WR_B:     begin wr_addr = BASE_ADDR + 32'h04;  wr_data = {28'b0, b_q};  wr_next = S_WR_SEL;   end
            S_WR_SEL:   begin wr_addr = BASE_ADDR + 32'h08;  wr_data = {31'b0, sel_q}; wr_next = S_WR_START; end
            S_WR_START: begin wr_addr = BASE_ADDR + 32'h0C;  wr_data = 32'h1;          wr_next = S_RD_DONE;  end
            S_RD_P:     rd_addr = BASE_ADDR + 32'h10;
            default:    ;
        endcase
    end

    assign is_wr = (state_q == S_WR_A) || (state_q == S_WR_B) ||
                   (state_q == S_WR_SEL) || (state_q == S_WR_START);
    assign is_rd = (state_q == S_RD_DONE) || (state_q == S_RD_P);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ar_done_d = ar_done_q;
        err_d     = err_q;
        p_d       = p_q;
`ifdef POLL_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        M_AXI_AWADDR  = 32'h0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WDATA   = 32'h0;
        M_AXI_WSTRB   = 4'h0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARADDR  = 32'h0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;

        if (state_q == S_IDLE) begin
            cmd_ready = 1'b1;
`ifdef POLL_TIMEOUT_EN
            cnt_d     = '0;
`endif
            if (cmd_valid) begin
                a_d     = cmd_a;
                b_d     = cmd_b;
                sel_d   = cmd_select;
                err_d   = 1'b0;
                state_d = S_WR_A;
            end
        end

        // AW and W complete independently; each VALID drops once its own handshake is seen.
        if (is_wr) begin
            M_AXI_AWADDR  = wr_addr;
            M_AXI_WDATA   = wr_data;
            M_AXI_WSTRB   = 4'hF;
            M_AXI_AWVALID = !aw_done_q;
            M_AXI_WVALID  = !w_done_q;
            M_AXI_BREADY  = 1'b1;
            if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
            if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
            if (M_AXI_BVALID) begin
                if (M_AXI_BRESP != 2'b00) err_d = 1'b1;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = wr_next;
            end
        end

        if (is_rd) begin
            M_AXI_ARADDR  = rd_addr;
            M_AXI_ARVALID = !ar_done_q;
            M_AXI_RREADY  = 1'b1;
            if (M_AXI_ARVALID && M_AXI_ARREADY) ar_done_d = 1'b1;
            if (M_AXI_RVALID) begin
                ar_done_d = 1'b0;
                if (M_AXI_RRESP != 2'b00) err_d = 1'b1;
                if (state_q == S_RD_P) begin
                    p_d     = M_AXI_RDATA[29:0];
                    state_d = S_RESP;
                end else if (M_AXI_RDATA[0]) begin
                    state_d = S_RD_P;
                end else begin
`ifdef POLL_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(POLL_LIMIT - 1)) begin
                        err_d   = 1'b1;
                        p_d     = '0;
                        state_d = S_RESP;
                    end
`endif
                end
            end
        end

        if (state_q == S_RESP) begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
        end
    end

    assign rsp_p   = p_q;
    assign rsp_err = (state_q == S_RESP) && err_q;

endmodule

// File: tb/tb_exp_mul_axi_cmd_master.sv
// Bench for exp_mul_axi_cmd_master: behavioural AXI4-Lite slave plus write/response scoreboards.
module tb_exp_mul_axi_cmd_master;
`ifdef POLL_TIMEOUT_EN
    localparam int PL = 8;
`else
    localparam int PL = 1024;
`endif
    localparam logic [31:0] BASE = 32'h7c800000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_select = 1'b0;
    logic [3:0]  cmd_a = '0, cmd_b = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [29:0] rsp_p;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    exp_mul_axi_cmd_master #(.BASE_ADDR(BASE), .POLL_LIMIT(PL), .CNT_W(11)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_select(cmd_select), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_p(rsp_p), .rsp_err(rsp_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    int tests = 0, fails = 0;
    logic [63:0] exp_wr_q[$];
    logic [30:0] exp_rsp_q[$];

    // Slave model knobs and observation counters.
    int          done_after = 0;
    bit          done_never = 0;
    bit          wdelay = 0;
    logic [29:0] p_val = '0;
    logic [31:0] berr_addr = 32'hFFFF_FFFF;
    int done_reads = 0, p_reads = 0, wr_count = 0, awv_after_hs = 0, wv_drop = 0, ovlp = 0, rsp_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : slave
        logic aw_got, w_got, ar_pend, hs_aw, hs_w, hs_b, hs_ar, hs_r;
        logic [31:0] aw_a, w_d, ar_a, s_awaddr, s_wdata, s_araddr;
        logic [63:0] e;
        int wcnt;
        aw_got = 0; w_got = 0; ar_pend = 0; wcnt = 0;
        hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
        aw_a = 0; w_d = 0; ar_a = 0; s_awaddr = 0; s_wdata = 0; s_araddr = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                aw_got = 0; w_got = 0; ar_pend = 0; wcnt = 0;
                hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            end else begin
                if (hs_aw) begin aw_got = 1; aw_a = s_awaddr; wcnt = 2; end
                if (hs_w)  begin w_got = 1; w_d = s_wdata; end
                if (hs_b)  bvalid = 0;
                if (hs_ar) begin ar_pend = 1; ar_a = s_araddr; end
                if (hs_r)  rvalid = 0;
                if (aw_got && w_got && !bvalid) begin
                    wr_count++;
                    if (exp_wr_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected none", aw_a, w_d);
                    end else begin
                        e = exp_wr_q.pop_front();
                        chk("wr_addr_data", {aw_a, w_d}, e);
                    end
                    bvalid = 1;
                    bresp = (aw_a == berr_addr) ? 2'b10 : 2'b00;
                    aw_got = 0; w_got = 0;
                end
                if (ar_pend && !rvalid) begin
                    ar_pend = 0; rvalid = 1; rresp = 2'b00; rdata = '0;
                    if (ar_a == BASE + 32'h14) begin
                        done_reads++;
                        rdata = (!done_never && done_reads > done_after) ? 32'h1 : 32'h0;
                    end else if (ar_a == BASE + 32'h10) begin
                        p_reads++;
                        rdata = {2'b00, p_val};
                    end else begin
                        tests++; fails++;
                        $display("FAIL rd_addr: got 0x%0h, expected DONE or P offset", ar_a);
                    end
                end
                if (awvalid && aw_got) awv_after_hs++;
                if (wdelay && aw_got && !w_got && !wvalid) wv_drop++;
                if ((awvalid || wvalid) && arvalid) ovlp++;
                awready = awvalid && !aw_got && !bvalid;
                if (wdelay) begin
                    if (aw_got && wcnt > 0) begin wcnt--; wready = 0; end
                    else wready = wvalid && aw_got && !w_got && !bvalid;
                end else begin
                    wready = wvalid && !w_got && !bvalid;
                end
                arready = arvalid && !ar_pend && !rvalid;
                hs_aw = awvalid && awready; hs_w = wvalid && wready; hs_b = bvalid && bready;
                hs_ar = arvalid && arready; hs_r = rvalid && rready;
                s_awaddr = awaddr; s_wdata = wdata; s_araddr = araddr;
            end
        end
    end

    initial begin : monitor
        logic [30:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                rsp_seen++;
                if (exp_rsp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL rsp_unexpected: got p=%0d err=%0b, expected none", rsp_p, rsp_err);
                end else begin
                    e = exp_rsp_q.pop_front();
                    chk("rsp_p", {34'b0, rsp_p}, {34'b0, e[29:0]});
                    chk("rsp_err", {63'b0, rsp_err}, {63'b0, e[30]});
                end
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic s);
        int n;
        exp_wr_q.push_back({BASE, 28'b0, a});
        exp_wr_q.push_back({BASE + 32'h04, 28'b0, b});
        exp_wr_q.push_back({BASE + 32'h08, 31'b0, s});
        exp_wr_q.push_back({BASE + 32'h0C, 32'h1});
        done_reads = 0; p_reads = 0; wr_count = 0;
        cmd_a = a; cmd_b = b; cmd_select = s; cmd_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 100);
        if (n >= 100) begin tests++; fails++; $display("FAIL cmd_accept: got no cmd_ready, expected it within 100 cycles"); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int prev);
        int n;
        n = 0;
        while (rsp_seen == prev && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin tests++; fails++; $display("FAIL rsp_timeout: got no response, expected one within 3000 cycles"); end
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int n;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        chk("reset_valids", {59'b0, awvalid, wvalid, arvalid, bready, rready}, 64'd0);
        chk("reset_rsp", {32'b0, rsp_valid, rsp_err, rsp_p}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Multiply job, DONE on the 4th poll.
        done_after = 3; p_val = 30'd15;
        exp_rsp_q.push_back({1'b0, 30'd15});
        send(4'd3, 4'd5, 1'b0);
        wait_rsp(0);
        chk("job1_done_reads", done_reads, 4);
        chk("job1_p_reads", p_reads, 1);

        // Exponent job with response backpressure.
        rsp_ready = 1'b0; done_after = 0; p_val = 30'd16;
        exp_rsp_q.push_back({1'b0, 30'd16});
        send(4'd2, 4'd4, 1'b1);
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_valid", {63'b0, rsp_valid}, 64'd1);
            chk("hold_p", {34'b0, rsp_p}, 64'd16);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("job2_consumed", rsp_seen, 2);
        @(negedge clk);
        chk("job2_cmd_ready", {62'b0, cmd_ready, rsp_valid}, 64'b10);
        @(posedge clk); #1;

        // WREADY lags AWREADY by two cycles.
        wdelay = 1; done_after = 2; p_val = 30'd63;
        exp_rsp_q.push_back({1'b0, 30'd63});
        send(4'd7, 4'd9, 1'b0);
        wait_rsp(2);
        wdelay = 0;
        chk("job3_awvalid_after_hs", awv_after_hs, 0);
        chk("job3_wvalid_drop", wv_drop, 0);
        chk("job3_write_count", wr_count, 4);
        chk("job3_done_reads", done_reads, 3);

        // SLVERR on the B write: sequence still completes.
        berr_addr = BASE + 32'h04; done_after = 0; p_val = 30'd5;
        exp_rsp_q.push_back({1'b1, 30'd5});
        send(4'd1, 4'd1, 1'b0);
        wait_rsp(3);
        berr_addr = 32'hFFFF_FFFF;
        chk("job4_p_reads", p_reads, 1);

`ifdef POLL_TIMEOUT_EN
        done_never = 1;
        exp_rsp_q.push_back({1'b1, 30'd0});
        send(4'd3, 4'd2, 1'b1);
        wait_rsp(4);
        done_never = 0;
        chk("timeout_done_reads", done_reads, 8);
        chk("timeout_p_reads", p_reads, 0);
`endif

        // Reset while polling DONE: job discarded, no response.
        done_never = 1;
        send(4'd3, 4'd3, 1'b0);
        n = 0;
        while (done_reads < 2 && n < 500) begin @(negedge clk); n++; end
        chk("rst_job_polling", {63'b0, done_reads >= 2}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_arvalid", {63'b0, arvalid}, 64'd0);
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'd1);
        chk("rst_writes_drained", exp_wr_q.size(), 0);
        exp_wr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        done_never = 0;

        // Normal job after the abort.
        done_after = 1; p_val = 30'd225;
        exp_rsp_q.push_back({1'b0, 30'd225});
`ifdef POLL_TIMEOUT_EN
        send(4'd15, 4'd15, 1'b0);
        wait_rsp(5);
        chk("final_rsp_count", rsp_seen, 6);
`else
        send(4'd15, 4'd15, 1'b0);
        wait_rsp(4);
        chk("final_rsp_count", rsp_seen, 5);
`endif
        chk("job6_done_reads", done_reads, 2);
        repeat (5) @(posedge clk);
        chk("ar_aw_overlap", ovlp, 0);
        chk("rsp_queue_empty", exp_rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
